// File: rtl/quad_decoder_pkg.sv
// Shared types and helpers for the quadrature decoder.
package quad_decoder_pkg;

  typedef enum logic {ST_INIT, ST_TRACK} qd_state_t;

  typedef logic [1:0] ab_t;

  // Gray-code positions of {A,B}; forward order is 00 -> 10 -> 11 -> 01 -> 00.
  localparam ab_t AB_00 = 2'b00;
  localparam ab_t AB_10 = 2'b10;
  localparam ab_t AB_11 = 2'b11;
  localparam ab_t AB_01 = 2'b01;

  // Successor of a pin state when A leads B.
  function automatic ab_t next_fwd(input ab_t ab);
    ab_t nxt;
    case (ab)
      AB_00:   nxt = AB_10;
      AB_10:   nxt = AB_11;
      AB_11:   nxt = AB_01;
      default: nxt = AB_00;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/quad_decoder_if.sv
// Encoder pins in, step/error/period results out.
interface quad_decoder_if #(
  parameter int PER_W = 16
);
  logic             a_in;
  logic             b_in;
  logic             err_clr;
  logic             locked;
  logic             step_up;
  logic             step_dn;
  logic             dir;
  logic             err_pulse;
  logic             err_sticky;
  logic [PER_W-1:0] period;
  logic             period_vld;

  // Encoder/consumer side.
  modport master (
    output a_in, b_in, err_clr,
    input  locked, step_up, step_dn, dir, err_pulse, err_sticky, period, period_vld
  );

  // Decoder side.
  modport slave (
    input  a_in, b_in, err_clr,
    output locked, step_up, step_dn, dir, err_pulse, err_sticky, period, period_vld
  );
endinterface

// File: rtl/quad_glitch_filter.sv
// One encoder channel: metastability synchronizer followed by a persistence
// filter. A change on the synchronized pin is accepted only after it has
// differed from the filtered value for FILTER_LEN consecutive cycles.
module quad_glitch_filter #(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pin,
  input  logic load,
  input  logic load_val,
  output logic sync,
  output logic filt
);

  localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam logic [CW-1:0] RUN_RELOAD = CW'(FILTER_LEN - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CW-1:0]          run_cnt;

  // Shift the asynchronous pin through the synchronizer chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pin};
    end
  end

  assign sync = sync_q[SYNC_STAGES-1];

  // Down-count the run of differing samples; terminal count accepts the change.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      filt    <= 1'b0;
      run_cnt <= '0;
    end else if (load) begin
      filt    <= load_val;
      run_cnt <= RUN_RELOAD;
    end else if (sync == filt) begin
      run_cnt <= RUN_RELOAD;
    end else if (run_cnt == '0) begin
      filt    <= sync;
      run_cnt <= RUN_RELOAD;
    end else begin
      run_cnt <= run_cnt - 1'b1;
    end
  end

endmodule

// File: rtl/quad_decoder.sv
// Quadrature decoder: filtered A/B pins to step strobes, direction, illegal
// transition flags and a saturating step-period measurement.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_INIT  | waiting for {a_s,b_s} to stay put, no strobes emitted
//   ST_TRACK | reference captured, decoding filtered pin transitions
module quad_decoder
  import quad_decoder_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 4,
  parameter int PER_W       = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  quad_decoder_if.slave  bus
);

  localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam logic [CW-1:0]    INIT_RELOAD = CW'(FILTER_LEN - 1);
  localparam logic [PER_W-1:0] PCNT_MAX    = '1;

  logic a_s, b_s, filt_a, filt_b, filt_load;
  ab_t  sync_ab, filt_ab, ab_prev;

  qd_state_t        state, state_nxt;
  logic [CW-1:0]    init_cnt, init_cnt_nxt;
  ab_t              ref_ab, ref_nxt;
  logic [PER_W-1:0] pcnt, pcnt_nxt, pcnt_inc;
  logic [PER_W-1:0] period_q, period_nxt;
  logic             locked_q;
  logic             step_up_q, step_up_nxt;
  logic             step_dn_q, step_dn_nxt;
  logic             dir_q, dir_nxt;
  logic             err_q, err_nxt;
  logic             err_sticky_q, err_sticky_nxt;
  logic             period_vld_q, period_vld_nxt;

  quad_glitch_filter #(
    .SYNC_STAGES (SYNC_STAGES),
    .FILTER_LEN  (FILTER_LEN)
  ) u_filt_a (
    .clk      (clk),
    .rst_n    (rst_n),
    .pin      (bus.a_in),
    .load     (filt_load),
    .load_val (a_s),
    .sync     (a_s),
    .filt     (filt_a)
  );

  quad_glitch_filter #(
    .SYNC_STAGES (SYNC_STAGES),
    .FILTER_LEN  (FILTER_LEN)
  ) u_filt_b (
    .clk      (clk),
    .rst_n    (rst_n),
    .pin      (bus.b_in),
    .load     (filt_load),
    .load_val (b_s),
    .sync     (b_s),
    .filt     (filt_b)
  );

  assign sync_ab = {a_s, b_s};
  assign filt_ab = {filt_a, filt_b};

  // Next-state, strobe and period computation.
  always_comb begin
    state_nxt      = state;
    init_cnt_nxt   = init_cnt;
    filt_load      = 1'b0;
    ref_nxt        = ref_ab;
    step_up_nxt    = 1'b0;
    step_dn_nxt    = 1'b0;
    err_nxt        = 1'b0;
    dir_nxt        = dir_q;
    period_nxt     = period_q;
    period_vld_nxt = 1'b0;
    pcnt_inc       = (pcnt == PCNT_MAX) ? pcnt : pcnt + 1'b1;
    pcnt_nxt       = pcnt;

    case (state)
      ST_INIT: begin
        if (sync_ab != ab_prev) begin
          init_cnt_nxt = INIT_RELOAD;
        end else if (init_cnt == '0) begin
          // Stable long enough: seed both filters and the reference together
          // so the first TRACK cycle sees no transition.
          state_nxt = ST_TRACK;
          filt_load = 1'b1;
          ref_nxt   = sync_ab;
          pcnt_nxt  = PCNT_MAX;
        end else begin
          init_cnt_nxt = init_cnt - 1'b1;
        end
      end

      ST_TRACK: begin
        pcnt_nxt = pcnt_inc;
        if (filt_ab != ref_ab) begin
          ref_nxt = filt_ab;
          if (filt_ab == next_fwd(ref_ab)) begin
            step_up_nxt    = 1'b1;
            dir_nxt        = 1'b1;
            period_nxt     = pcnt_inc;
            period_vld_nxt = 1'b1;
            pcnt_nxt       = '0;
          end else if (ref_ab == next_fwd(filt_ab)) begin
            step_dn_nxt    = 1'b1;
            dir_nxt        = 1'b0;
            period_nxt     = pcnt_inc;
            period_vld_nxt = 1'b1;
            pcnt_nxt       = '0;
          end else begin
            // Both bits moved at once: position is unknown, pcnt keeps running.
            err_nxt = 1'b1;
          end
        end
      end

      default: state_nxt = ST_INIT;
    endcase

    // A new error outranks a simultaneous clear.
    err_sticky_nxt = err_nxt | (err_sticky_q & ~bus.err_clr);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_INIT;
      init_cnt     <= INIT_RELOAD;
      ab_prev      <= AB_00;
      ref_ab       <= AB_00;
      pcnt         <= '0;
      period_q     <= '0;
      locked_q     <= 1'b0;
      step_up_q    <= 1'b0;
      step_dn_q    <= 1'b0;
      dir_q        <= 1'b0;
      err_q        <= 1'b0;
      err_sticky_q <= 1'b0;
      period_vld_q <= 1'b0;
    end else begin
      state        <= state_nxt;
      init_cnt     <= init_cnt_nxt;
      ab_prev      <= sync_ab;
      ref_ab       <= ref_nxt;
      pcnt         <= pcnt_nxt;
      period_q     <= period_nxt;
      locked_q     <= (state_nxt == ST_TRACK);
      step_up_q    <= step_up_nxt;
      step_dn_q    <= step_dn_nxt;
      dir_q        <= dir_nxt;
      err_q        <= err_nxt;
      err_sticky_q <= err_sticky_nxt;
      period_vld_q <= period_vld_nxt;
    end
  end

  assign bus.locked     = locked_q;
  assign bus.step_up    = step_up_q;
  assign bus.step_dn    = step_dn_q;
  assign bus.dir        = dir_q;
  assign bus.err_pulse  = err_q;
  assign bus.err_sticky = err_sticky_q;
  assign bus.period     = period_q;
  assign bus.period_vld = period_vld_q;

endmodule

// File: tb/tb_quad_decoder.sv
// Scoreboard bench for quad_decoder: each driven pin change pushes the event
// it must produce; the negedge monitor pops and compares strobes as they arrive.
module tb_quad_decoder;
  import quad_decoder_pkg::*;

  localparam int K_NONE = 0;
  localparam int K_UP   = 1;
  localparam int K_DN   = 2;
  localparam int K_ERR  = 3;
  localparam int LAT    = 7;
  localparam int PMAX   = 65535;

  typedef struct {
    int kind;
    int t;
    int per;
    int dir;
  } ev_t;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;
  ev_t  sb[$];

  int   m_first = 1;
  int   m_last_t = 0;
  int   m_per = 0;
  int   m_dir = 0;

  quad_decoder_if #(.PER_W(16)) bus ();

  quad_decoder #(
    .SYNC_STAGES (2),
    .FILTER_LEN  (4),
    .PER_W       (16)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Free-running clock and cycle count.
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Compare every strobe against the oldest expected event.
  always @(negedge clk) begin : mon
    int  k;
    ev_t e;
    if (rst_n && (bus.step_up || bus.step_dn || bus.err_pulse)) begin
      k = bus.err_pulse ? K_ERR : (bus.step_up ? K_UP : K_DN);
      chk("strobe_exclusive", {31'd0, bus.step_up & bus.step_dn}, 0);
      if (sb.size() == 0) begin
        chk("unexpected_event", k, K_NONE);
      end else begin
        e = sb.pop_front();
        chk("event_kind", k, e.kind);
        chk("event_cycle", cyc, e.t);
        chk("period", {16'd0, bus.period}, e.per);
        chk("dir", {31'd0, bus.dir}, e.dir);
        chk("period_vld", {31'd0, bus.period_vld}, (e.kind != K_ERR) ? 1 : 0);
      end
    end
  end

  task automatic model_reset();
    m_first = 1;
    m_per   = 0;
    m_dir   = 0;
  endtask

  // Drive {A,B} at a negedge, record the expected event, hold for 'hold' cycles.
  task automatic drive(input logic [1:0] ab, input int kind, input int hold);
    ev_t e;
    @(negedge clk);
    bus.a_in = ab[1];
    bus.b_in = ab[0];
    if (kind != K_NONE) begin
      e.kind = kind;
      e.t    = cyc + LAT;
      if (kind == K_ERR) begin
        e.per = m_per;
        e.dir = m_dir;
      end else begin
        if (m_first != 0) e.per = PMAX;
        else e.per = ((e.t - m_last_t) > PMAX) ? PMAX : (e.t - m_last_t);
        m_first  = 0;
        m_last_t = e.t;
        m_per    = e.per;
        m_dir    = (kind == K_UP) ? 1 : 0;
        e.dir    = m_dir;
      end
      sb.push_back(e);
    end
    repeat (hold - 1) @(negedge clk);
  endtask

  task automatic wait_lock(input string tag);
    int n = 0;
    while (!bus.locked && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk(tag, {31'd0, (bus.locked && n <= LAT)}, 1);
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("sb_drained", sb.size(), 0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk(tag, {9'd0, bus.locked, bus.step_up, bus.step_dn, bus.dir, bus.err_pulse,
              bus.err_sticky, bus.period_vld, bus.period}, 0);
  endtask

  // Bound the whole run.
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n       = 1'b0;
    bus.a_in    = 1'b1;
    bus.b_in    = 1'b1;
    bus.err_clr = 1'b0;

    // 1: lock with pins at 11
    repeat (3) @(negedge clk);
    chk_reset_outputs("reset_values");
    rst_n = 1'b1;
    wait_lock("lock_11");
    chk("filt_11", {30'd0, dut.filt_a, dut.filt_b}, 3);
    repeat (10) @(negedge clk);

    // Re-lock at 00 so the forward run starts from a fresh lock
    @(negedge clk);
    rst_n    = 1'b0;
    bus.a_in = 1'b0;
    bus.b_in = 1'b0;
    repeat (3) @(negedge clk);
    model_reset();
    rst_n = 1'b1;
    wait_lock("lock_00");
    repeat (10) @(negedge clk);

    // 2: forward cycle
    drive(AB_10, K_UP, 20);
    drive(AB_11, K_UP, 20);
    drive(AB_01, K_UP, 20);
    drive(AB_00, K_UP, 20);
    drain();
    chk("dir_after_fwd", {31'd0, bus.dir}, 1);

    // 3: reverse cycle
    drive(AB_01, K_DN, 20);
    drive(AB_11, K_DN, 20);
    drive(AB_10, K_DN, 20);
    drive(AB_00, K_DN, 20);
    drain();
    chk("dir_after_rev", {31'd0, bus.dir}, 0);

    // 4: 3-cycle glitch rejected, 4-cycle pulse accepted both ways
    drive(AB_10, K_NONE, 3);
    drive(AB_00, K_NONE, 20);
    drive(AB_10, K_UP, 4);
    drive(AB_00, K_DN, 20);
    drain();
    chk("no_err_after_pulses", {31'd0, bus.err_sticky}, 0);

    // 5: simultaneous change, clear, and clear colliding with a new error
    drive(AB_11, K_ERR, 20);
    chk("err_sticky_set", {31'd0, bus.err_sticky}, 1);
    @(negedge clk);
    bus.err_clr = 1'b1;
    @(negedge clk);
    bus.err_clr = 1'b0;
    chk("err_sticky_cleared", {31'd0, bus.err_sticky}, 0);
    drive(AB_00, K_ERR, LAT);
    bus.err_clr = 1'b1;
    @(negedge clk);
    bus.err_clr = 1'b0;
    chk("err_set_wins", {31'd0, bus.err_sticky}, 1);
    repeat (20) @(negedge clk);

    // 6: long stall saturates the period
    repeat (70000) @(negedge clk);
    drive(AB_10, K_UP, 20);
    drive(AB_11, K_UP, 20);
    drain();

    // Mid-operation reset clears outputs immediately, then re-locks at 11
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("async_reset_outputs");
    repeat (3) @(negedge clk);
    model_reset();
    rst_n = 1'b1;
    wait_lock("relock_11");
    repeat (5) @(negedge clk);
    drive(AB_01, K_UP, 20);
    drain();

    chk("sb_empty_final", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
